// File: rtl/digit_write_arbiter.sv
// Round-robin arbiter that serialises one 16-bit word per grant onto the 4-slot nibble demux.
// Each slot (select + nibble) is held with WrEn for HOLD cycles, then the owner gets a one-cycle Ack.
module digit_write_arbiter #(
    parameter int NREQ = 2,
    parameter int HOLD = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      Req,
    input  logic [16*NREQ-1:0]   Data,
    output logic [NREQ-1:0]      Ack,
    output logic                 Busy,
    output logic [1:0]           Sel,
    output logic [3:0]           Nib,
    output logic                 WrEn
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);
    localparam logic [1:0] LAST_IDX  = 2'(NREQ - 1);

    state_t            state_r, state_s;
    logic [1:0]        grant_r, grant_s;
    logic [1:0]        rr_r, rr_s;
    logic [15:0]       holding_r, holding_s;
    logic [1:0]        slot_r, slot_s;
    logic [3:0]        hold_cnt_r, hold_cnt_s;
    logic              arb_found_s;
    logic [1:0]        arb_idx_s;

    logic [NREQ-1:0]   ack_r, ack_s;
    logic              busy_r, busy_s;
    logic [1:0]        sel_r, sel_s;
    logic [3:0]        nib_r, nib_s;
    logic              wr_en_r, wr_en_s;

    // Lowest set request at or above ptr wins; otherwise lowest set request below ptr.
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
        logic       hi_found;
        logic [1:0] hi_idx;
        logic       lo_found;
        logic [1:0] lo_idx;
        hi_found = 1'b0;
        hi_idx   = 2'd0;
        lo_found = 1'b0;
        lo_idx   = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = i[1:0];
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = i[1:0];
                end else begin
                    hi_found = hi_found;
                end
            end else begin
                lo_found = lo_found;
            end
        end
        if (hi_found) begin
            return {1'b1, hi_idx};
        end else begin
            return {lo_found, lo_idx};
        end
    endfunction

    assign {arb_found_s, arb_idx_s} = rr_pick(Req, rr_r);

    // Control and datapath state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= 2'd0;
            rr_r       <= 2'd0;
            holding_r  <= 16'h0000;
            slot_r     <= 2'd0;
            hold_cnt_r <= 4'd0;
        end else begin
            state_r    <= state_s;
            grant_r    <= grant_s;
            rr_r       <= rr_s;
            holding_r  <= holding_s;
            slot_r     <= slot_s;
            hold_cnt_r <= hold_cnt_s;
        end
    end

    // Next-state logic; the ACK cycle also arbitrates so a pending requester follows back-to-back.
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        rr_s       = rr_r;
        holding_s  = holding_r;
        slot_s     = slot_r;
        hold_cnt_s = hold_cnt_r;
        case (state_r)
            ST_IDLE, ST_ACK: begin
                if (arb_found_s) begin
                    state_s    = ST_WRITE;
                    grant_s    = arb_idx_s;
                    slot_s     = 2'd0;
                    hold_cnt_s = 4'd0;
                    if (arb_idx_s == LAST_IDX) begin
                        rr_s = 2'd0;
                    end else begin
                        rr_s = arb_idx_s + 2'd1;
                    end
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_idx_s == i[1:0]) begin
                            holding_s = Data[16*i +: 16];
                        end else begin
                            holding_s = holding_s;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    hold_cnt_s = 4'd0;
                    if (slot_r == 2'd3) begin
                        state_s = ST_ACK;
                    end else begin
                        slot_s = slot_r + 2'd1;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r + 4'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so outputs can be registered.
    always_comb begin
        ack_s   = {NREQ{1'b0}};
        busy_s  = 1'b0;
        sel_s   = sel_r;
        nib_s   = nib_r;
        wr_en_s = 1'b0;
        case (state_s)
            ST_WRITE: begin
                busy_s  = 1'b1;
                wr_en_s = 1'b1;
                sel_s   = slot_s;
                nib_s   = holding_s[{slot_s, 2'b00} +: 4];
            end
            ST_ACK: begin
                busy_s = 1'b1;
                for (int i = 0; i < NREQ; i++) begin
                    ack_s[i] = (grant_s == i[1:0]);
                end
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ack_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            sel_r   <= 2'd0;
            nib_r   <= 4'd0;
            wr_en_r <= 1'b0;
        end else begin
            ack_r   <= ack_s;
            busy_r  <= busy_s;
            sel_r   <= sel_s;
            nib_r   <= nib_s;
            wr_en_r <= wr_en_s;
        end
    end

    assign Ack  = ack_r;
    assign Busy = busy_r;
    assign Sel  = sel_r;
    assign Nib  = nib_r;
    assign WrEn = wr_en_r;

endmodule

// File: tb/tb_digit_write_arbiter.sv
// Directed table-driven bench for digit_write_arbiter (HOLD=1 instance) plus a HOLD=3 sequence.
module tb_digit_write_arbiter;

    logic        Clock;
    logic        Reset;
    logic [1:0]  Req;
    logic [31:0] Data;
    logic [1:0]  Ack;
    logic        Busy;
    logic [1:0]  Sel;
    logic [3:0]  Nib;
    logic        WrEn;

    logic        h3_rst;
    logic [1:0]  h3_req;
    logic [31:0] h3_data;
    logic [1:0]  h3_ack;
    logic        h3_busy;
    logic [1:0]  h3_sel;
    logic [3:0]  h3_nib;
    logic        h3_wren;

    int checks;
    int errors;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [9:0]  exp;
    } vec_t;

    vec_t tbl[$];

    digit_write_arbiter #(.NREQ(2), .HOLD(1)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Data(Data),
        .Ack(Ack), .Busy(Busy), .Sel(Sel), .Nib(Nib), .WrEn(WrEn)
    );

    digit_write_arbiter #(.NREQ(2), .HOLD(3)) dut3 (
        .Clock(Clock), .Reset(h3_rst), .Req(h3_req), .Data(h3_data),
        .Ack(h3_ack), .Busy(h3_busy), .Sel(h3_sel), .Nib(h3_nib), .WrEn(h3_wren)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Packed expectation: {ack[1:0], busy, sel[1:0], nib[3:0], wren}
    function automatic logic [9:0] o(input logic [1:0] ack, input logic busy,
                                     input logic [1:0] sel, input logic [3:0] nib,
                                     input logic wren);
        return {ack, busy, sel, nib, wren};
    endfunction

    task automatic add(input logic rst, input logic [1:0] req, input logic [15:0] d0,
                       input logic [15:0] d1, input logic [9:0] exp);
        vec_t v;
        v.rst = rst; v.req = req; v.d0 = d0; v.d1 = d1; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [9:0] act,
                         input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got ack=%b busy=%b sel=%0d nib=%h wren=%b, want ack=%b busy=%b sel=%0d nib=%h wren=%b",
                     name, idx, act[9:8], act[7], act[6:5], act[4:1], act[0],
                     exp[9:8], exp[7], exp[6:5], exp[4:1], exp[0]);
        end
    endtask

    initial begin
        logic [9:0]  exp3;
        logic [1:0]  s3;
        checks  = 0;
        errors  = 0;
        Reset   = 1'b1;
        Req     = 2'b00;
        Data    = 32'h0000_0000;
        h3_rst  = 1'b1;
        h3_req  = 2'b00;
        h3_data = 32'h0000_0000;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) add(1'b1, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b0, 2'd0, 4'h0, 1'b0));

        // Single word from requester 0; data changes after grant must not matter
        add(1'b0, 2'b01, 16'hA3C5, 16'h0000, o(2'b00, 1'b1, 2'd0, 4'h5, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b1, 2'd1, 4'hC, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b1, 2'd2, 4'h3, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b1, 2'd3, 4'hA, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b01, 1'b1, 2'd3, 4'hA, 1'b0));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b0, 2'd3, 4'hA, 1'b0));

        // Reset to bring rr pointer back to 0, then both requesters held high
        add(1'b1, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b0, 2'd0, 4'h0, 1'b0));
        for (int g = 0; g < 4; g++) begin
            for (int s = 0; s < 4; s++) begin
                add(1'b0, 2'b11, 16'h1111, 16'h2222,
                    o(2'b00, 1'b1, 2'(s), (g % 2 == 0) ? 4'h1 : 4'h2, 1'b1));
            end
            add(1'b0, 2'b11, 16'h1111, 16'h2222,
                o((g % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 2'd3, (g % 2 == 0) ? 4'h1 : 4'h2, 1'b0));
        end
        add(1'b0, 2'b00, 16'h1111, 16'h2222, o(2'b00, 1'b0, 2'd3, 4'h2, 1'b0));

        // Reset while Sel=2 aborts; later requester 1 transfer
        add(1'b0, 2'b01, 16'h8765, 16'h0000, o(2'b00, 1'b1, 2'd0, 4'h5, 1'b1));
        add(1'b0, 2'b00, 16'h8765, 16'h0000, o(2'b00, 1'b1, 2'd1, 4'h6, 1'b1));
        add(1'b0, 2'b00, 16'h8765, 16'h0000, o(2'b00, 1'b1, 2'd2, 4'h7, 1'b1));
        add(1'b1, 2'b01, 16'h8765, 16'h0000, o(2'b00, 1'b0, 2'd0, 4'h0, 1'b0));
        add(1'b0, 2'b00, 16'h8765, 16'h0000, o(2'b00, 1'b0, 2'd0, 4'h0, 1'b0));
        add(1'b0, 2'b10, 16'h0000, 16'h4321, o(2'b00, 1'b1, 2'd0, 4'h1, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b1, 2'd1, 4'h2, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b1, 2'd2, 4'h3, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b1, 2'd3, 4'h4, 1'b1));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b10, 1'b1, 2'd3, 4'h4, 1'b0));
        add(1'b0, 2'b00, 16'h0000, 16'h0000, o(2'b00, 1'b0, 2'd3, 4'h4, 1'b0));

        // Requester 1 arrives during requester 0's transfer; granted on the edge closing Ack0
        add(1'b0, 2'b01, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd0, 4'hF, 1'b1));
        add(1'b0, 2'b10, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd1, 4'hE, 1'b1));
        add(1'b0, 2'b10, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd2, 4'hE, 1'b1));
        add(1'b0, 2'b10, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd3, 4'hB, 1'b1));
        add(1'b0, 2'b10, 16'hBEEF, 16'h5A5A, o(2'b01, 1'b1, 2'd3, 4'hB, 1'b0));
        add(1'b0, 2'b10, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd0, 4'hA, 1'b1));
        add(1'b0, 2'b00, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd1, 4'h5, 1'b1));
        add(1'b0, 2'b00, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd2, 4'hA, 1'b1));
        add(1'b0, 2'b00, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b1, 2'd3, 4'h5, 1'b1));
        add(1'b0, 2'b00, 16'hBEEF, 16'h5A5A, o(2'b10, 1'b1, 2'd3, 4'h5, 1'b0));
        add(1'b0, 2'b00, 16'hBEEF, 16'h5A5A, o(2'b00, 1'b0, 2'd3, 4'h5, 1'b0));

        // Inputs for row i are applied during a cycle; outputs checked just after the closing edge
        for (int i = 0; i < tbl.size(); i++) begin
            Reset = tbl[i].rst;
            Req   = tbl[i].req;
            Data  = {tbl[i].d1, tbl[i].d0};
            @(posedge Clock);
            #1;
            check("vec", i, {Ack, Busy, Sel, Nib, WrEn}, tbl[i].exp);
        end

        // HOLD=3: one-cycle Req0 pulse, data overwritten right after grant
        h3_rst  = 1'b0;
        h3_req  = 2'b01;
        h3_data = 32'h0000_0F0F;
        for (int c = 1; c <= 14; c++) begin
            @(posedge Clock);
            #1;
            if (c == 1) begin
                h3_req  = 2'b00;
                h3_data = 32'h0000_FFFF;
            end
            if (c <= 12) begin
                s3   = 2'((c - 1) / 3);
                exp3 = o(2'b00, 1'b1, s3, (s3[0] == 1'b0) ? 4'hF : 4'h0, 1'b1);
            end else if (c == 13) begin
                exp3 = o(2'b01, 1'b1, 2'd3, 4'h0, 1'b0);
            end else begin
                exp3 = o(2'b00, 1'b0, 2'd3, 4'h0, 1'b0);
            end
            check("hold3", c, {h3_ack, h3_busy, h3_sel, h3_nib, h3_wren}, exp3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
